fg_fetch: RTL and testbench
===========================

# fg_fetch

Foreground fetch stage sitting directly upstream of the compositing pipeline's foreground input. It takes the pipeline's per-cycle signed foreground coordinate request, range-checks it, turns in-range requests into SRAM reads, and returns pixel/skip responses exactly `FETCH_DELAY` cycles after each request. It also arbitrates a foreground writer into SRAM slots left free by skipped or idle requests, and manages a two-page (double-buffered) foreground frame store.

## Interface
- `RESOLUTION_X`, 1920, foreground frame width in pixels
- `RESOLUTION_Y`, 1080, foreground frame height in pixels
- `SRAM_LATENCY`, 2, cycles from SRAM read strobe to valid `sram_rdata`
- `FETCH_DELAY`, 4, request-to-response latency; must equal the pipeline's foreground fetch delay; requires `FETCH_DELAY >= SRAM_LATENCY + 2`
- `ADDR_WIDTH`, 22, SRAM address width: MSB is the page bit, the low 21 bits are the in-page pixel index
---
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_x`, `req_y`  in  13 signed  requested foreground coordinate
- `req_active`  in  1  request valid this cycle
- `fg_pixel_in`  out  16  returned RGB565 pixel
- `fg_pixel_skip`  out  1  response carries no pixel (out of range)
- `fg_pixel_ready`  out  1  response valid this cycle
- `sram_addr`  out  ADDR_WIDTH  SRAM address
- `sram_re`  out  1  read strobe
- `sram_we`  out  1  write strobe
- `sram_wdata`  out  16  write data
- `sram_rdata`  in  16  read data
- `wr_valid`  in  1  writer has a pixel
- `wr_addr`  in  ADDR_WIDTH-1  in-page pixel index to write
- `wr_data`  in  16  pixel to write
- `wr_ready`  out  1  write accepted this cycle (combinational)
- `swap_req`  in  1  one-cycle pulse: request page swap
- `frame_start`  in  1  one-cycle pulse at start of output frame
- `read_page`  out  1  page currently being displayed

## Operation
- In range: `0 <= req_x < RESOLUTION_X` and `0 <= req_y < RESOLUTION_Y`, using signed compares. Negative coordinates are out of range.
- Request with `req_active` high and in range: issue a read at `{read_page, req_y*RESOLUTION_X + req_x}`. The index is computed at 21 bits; the product must not truncate.
- Request with `req_active` high and out of range: no SRAM access; the response has skip=1 and pixel=0.
- `req_active` low: no response is generated.
- `wr_ready = !(req_active && in_range)`. On `wr_valid && wr_ready`, issue a write at `{~read_page, wr_addr}` with `wr_data`. Reads and writes are therefore mutually exclusive by construction.
- The write page is sampled in the acceptance cycle. If the page toggles in that same cycle, the pre-toggle value is used.
- A shift register of depth `FETCH_DELAY` carries {active, skip} per request. A data register chain aligns `sram_rdata` to the response slot.
- Page state:
  - `swap_req` sets `swap_pending`.
  - `frame_start` with `swap_pending` set toggles `read_page` and clears `swap_pending`.
  - `swap_req` and `frame_start` in the same cycle: the toggle happens in that cycle.
  - A repeated `swap_req` while pending has no further effect.
- Reset values: all outputs 0, `read_page=0`, `swap_pending=0`, delay line cleared. Asserting `rst` mid-operation discards all in-flight responses; no `fg_pixel_ready` pulse may follow the reset for requests issued before it.

## Timing
- Request sampled in cycle N:
  - `sram_re`/`sram_addr` registered, high in cycle N+1.
  - `sram_rdata` valid in cycle N+1+SRAM_LATENCY.
  - `fg_pixel_ready`, `fg_pixel_skip`, `fg_pixel_in` registered, valid in cycle N+FETCH_DELAY exactly, for one cycle.
- Back-to-back requests every cycle give back-to-back responses with no bubbles; throughput is 1 per cycle.
- Write accepted in cycle N: `sram_we`, `sram_addr`, `sram_wdata` high/valid in cycle N+1 for one cycle.
- `sram_re` and `sram_we` are never high in the same cycle.
- `read_page` toggle takes effect on the cycle after `frame_start`. Reads sampled in that `frame_start` cycle use the old page.
- `fg_pixel_in` is 0 whenever `fg_pixel_ready` is low or `fg_pixel_skip` is high.

## Test plan
- Request (x=5, y=2, active) in cycle 10, SRAM model returning 0xF800 at address 3845: `sram_re` in cycle 11 with addr 3845, response ready=1, skip=0, pixel=0xF800 in cycle 14 only.
- Requests x=-1, x=1920, y=1080 and (0,0): first three give ready=1, skip=1, pixel=0 with no `sram_re`; (0,0) reads addr 0. Also (1919,1079) reads addr 2073599.
- Continuous requests with `wr_valid` held high: `wr_ready` low on in-range cycles and high on skip/idle cycles; each accepted write appears on the SRAM port one cycle later at `{1, wr_addr}`; `re` and `we` are never both high.
- `swap_req` pulse, then `frame_start` 100 cycles later: `read_page` goes 0->1 the cycle after; subsequent reads use MSB=1 and writes use MSB=0. A second `frame_start` with no `swap_req` causes no change.
- Stream 6 requests, assert `rst` 2 cycles after the last: all outputs 0 during and after reset, no stale `fg_pixel_ready`; a new request after release responds correctly 4 cycles later.

Source files
------------

// File: rtl/fg_fetch_if.sv
// fg_fetch_if: bundles the foreground request/response, SRAM and writer
// buses of fg_fetch.
//   slave  : fetch-stage view (takes requests, drives responses and SRAM)
//   master : environment view (pipeline, SRAM model, writer)
interface fg_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 22
);
  // pipeline request / response
  logic signed [12:0]       req_x;
  logic signed [12:0]       req_y;
  logic                     req_active;
  logic [15:0]              fg_pixel_in;
  logic                     fg_pixel_skip;
  logic                     fg_pixel_ready;
  // SRAM port
  logic [ADDR_WIDTH-1:0]    sram_addr;
  logic                     sram_re;
  logic                     sram_we;
  logic [15:0]              sram_wdata;
  logic [15:0]              sram_rdata;
  // foreground writer
  logic                     wr_valid;
  logic [ADDR_WIDTH-2:0]    wr_addr;
  logic [15:0]              wr_data;
  logic                     wr_ready;

  modport slave (
    input  req_x, req_y, req_active, sram_rdata, wr_valid, wr_addr, wr_data,
    output fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
           sram_addr, sram_re, sram_we, sram_wdata, wr_ready
  );

  modport master (
    output req_x, req_y, req_active, sram_rdata, wr_valid, wr_addr, wr_data,
    input  fg_pixel_in, fg_pixel_skip, fg_pixel_ready,
           sram_addr, sram_re, sram_we, sram_wdata, wr_ready
  );
endinterface

// File: rtl/fg_fetch.sv
// fg_fetch: foreground fetch stage. Range-checks signed coordinate requests,
// reads in-range pixels from SRAM, and answers every active request exactly
// FETCH_DELAY cycles later with a pixel or a skip. Writer pixels fill SRAM
// slots not used by reads, always into the page not being displayed.
// Ports:
//   clk, rst      pixel clock, asynchronous active-high reset
//   bus           fg_fetch_if.slave (request, response, SRAM, writer)
//   swap_req      pulse: request a page swap at the next frame start
//   frame_start   pulse: start of output frame
//   read_page     page currently displayed
module fg_fetch #(
  parameter int unsigned RESOLUTION_X = 1920,
  parameter int unsigned RESOLUTION_Y = 1080,
  parameter int unsigned SRAM_LATENCY = 2,
  parameter int unsigned FETCH_DELAY  = 4,
  parameter int unsigned ADDR_WIDTH   = 22
) (
  input  logic       clk,
  input  logic       rst,
  fg_fetch_if.slave  bus,
  input  logic       swap_req,
  input  logic       frame_start,
  output logic       read_page
);
  localparam int unsigned IDX_W    = ADDR_WIDTH - 1;
  localparam int unsigned STG      = FETCH_DELAY - 1;
  localparam int unsigned DATA_DLY = FETCH_DELAY - SRAM_LATENCY - 2;
  localparam logic signed [12:0] RES_X_S = 13'(RESOLUTION_X);
  localparam logic signed [12:0] RES_Y_S = 13'(RESOLUTION_Y);

  // ---------------- request decode ----------------
  logic             in_range_c;
  logic             rd_hit_c;
  logic             wr_acc_c;
  logic [IDX_W-1:0] idx_c;

  assign in_range_c = (bus.req_x >= 13'sd0) && (bus.req_x < RES_X_S) &&
                      (bus.req_y >= 13'sd0) && (bus.req_y < RES_Y_S);
  assign rd_hit_c   = bus.req_active && in_range_c;
  // Writer only gets the SRAM when no read is issued; held off during reset.
  assign bus.wr_ready = !rst && !rd_hit_c;
  assign wr_acc_c     = bus.wr_valid && bus.wr_ready;

  // In range both coordinates fit in 12 unsigned bits; full-width product.
  assign idx_c = IDX_W'(bus.req_y[11:0]) * IDX_W'(RESOLUTION_X) +
                 IDX_W'(bus.req_x[11:0]);

  // ---------------- page state (double buffer) ----------------
  logic page_q, page_d;
  logic pend_q, pend_d;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      page_q <= page_d;
      pend_q <= pend_d;
    end
  end

  // next state: a swap_req in the frame_start cycle swaps immediately
  always_comb begin
    page_d = page_q;
    pend_d = pend_q;
    if (frame_start && (pend_q || swap_req)) begin
      page_d = ~page_q;
      pend_d = 1'b0;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  // outputs
  always_comb begin
    read_page = page_q;
  end

  // ---------------- SRAM port ----------------
  logic                  sram_re_q;
  logic                  sram_we_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [15:0]           sram_wdata_q;

  // Both read and write use the page value before any toggle this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_re_q    <= rd_hit_c;
      sram_we_q    <= wr_acc_c;
      sram_wdata_q <= wr_acc_c ? bus.wr_data : 16'h0000;
      if (rd_hit_c)
        sram_addr_q <= {page_q, idx_c};
      else if (wr_acc_c)
        sram_addr_q <= {~page_q, bus.wr_addr};
      else
        sram_addr_q <= '0;
    end
  end

  assign bus.sram_re    = sram_re_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

  // ---------------- response delay line ----------------
  logic [STG-1:0] act_q;
  logic [STG-1:0] skp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= '0;
      skp_q <= '0;
    end else begin
      act_q[0] <= bus.req_active;
      skp_q[0] <= bus.req_active && !in_range_c;
      for (int i = 1; i < int'(STG); i++) begin
        act_q[i] <= act_q[i-1];
        skp_q[i] <= skp_q[i-1];
      end
    end
  end

  // Read data lands DATA_DLY cycles before the output register samples it.
  logic [15:0] rd_aligned_c;

  generate
    if (DATA_DLY == 0) begin : g_no_dly
      assign rd_aligned_c = bus.sram_rdata;
    end else begin : g_dly
      logic [15:0] dchain_q [DATA_DLY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(DATA_DLY); i++) dchain_q[i] <= 16'h0000;
        end else begin
          dchain_q[0] <= bus.sram_rdata;
          for (int i = 1; i < int'(DATA_DLY); i++) dchain_q[i] <= dchain_q[i-1];
        end
      end
      assign rd_aligned_c = dchain_q[DATA_DLY-1];
    end
  endgenerate

  // ---------------- response registers ----------------
  logic        rdy_q;
  logic        skip_q;
  logic [15:0] pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      skip_q <= 1'b0;
      pix_q  <= 16'h0000;
    end else begin
      rdy_q  <= act_q[STG-1];
      skip_q <= act_q[STG-1] && skp_q[STG-1];
      pix_q  <= (act_q[STG-1] && !skp_q[STG-1]) ? rd_aligned_c : 16'h0000;
    end
  end

  assign bus.fg_pixel_ready = rdy_q;
  assign bus.fg_pixel_skip  = skip_q;
  assign bus.fg_pixel_in    = pix_q;

endmodule

// File: tb/tb_fg_fetch.sv
// tb_fg_fetch: directed + randomized bench for fg_fetch. A cycle-indexed
// expectation table is filled from the coordinate/page rules; an independent
// SRAM model answers the DUT's port with SRAM_LATENCY cycles of delay.
module tb_fg_fetch;
  localparam int unsigned FD   = 4;
  localparam int unsigned L    = 2;
  localparam int unsigned AW   = 22;
  localparam int          RX   = 1920;
  localparam int          RY   = 1080;
  localparam int          MAXC = 4096;

  logic clk;
  logic rst;
  logic swap_req;
  logic frame_start;
  logic read_page;

  fg_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  fg_fetch #(
    .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .SRAM_LATENCY(L),
    .FETCH_DELAY(FD), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .swap_req(swap_req), .frame_start(frame_start), .read_page(read_page)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expectations per cycle
  bit          e_rdy [MAXC];
  bit          e_skp [MAXC];
  logic [15:0] e_pix [MAXC];
  bit          e_re  [MAXC];
  bit          e_we  [MAXC];
  logic [AW-1:0] e_ad [MAXC];
  logic [15:0] e_wd  [MAXC];
  // environment SRAM read history
  bit          env_re [MAXC];
  logic [15:0] env_rd [MAXC];

  logic [15:0] mem_ref [int];
  logic [15:0] mem_env [int];

  int cyc;
  int checks;
  int failures;
  bit m_page;
  bit m_pend;

  function automatic logic [15:0] seed_val(int a);
    return 16'((a * 40503) ^ (a >> 7));
  endfunction

  function automatic logic [15:0] ref_rd(int a);
    return mem_ref.exists(a) ? mem_ref[a] : seed_val(a);
  endfunction

  function automatic logic [15:0] env_read(int a);
    return mem_env.exists(a) ? mem_env[a] : seed_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input bit act, input int x, input int y);
    bus.req_active = act;
    bus.req_x      = 13'(x);
    bus.req_y      = 13'(y);
  endtask

  // One clock cycle: called just after a rising edge with inputs driven.
  task automatic step();
    int  x, y, a;
    bit  inr;
    if (rst) begin
      for (int k = cyc; k < cyc + int'(FD) + 2; k++) begin
        e_rdy[k] = 0; e_skp[k] = 0; e_pix[k] = '0;
        e_re[k]  = 0; e_we[k]  = 0;
      end
      m_page = 0;
      m_pend = 0;
    end
    bus.sram_rdata = (cyc >= int'(L) && env_re[cyc-int'(L)]) ? env_rd[cyc-int'(L)]
                                                             : 16'($urandom);
    #3;
    chk("ready", 32'(bus.fg_pixel_ready), 32'(e_rdy[cyc]));
    chk("skip", 32'(bus.fg_pixel_skip), 32'(e_skp[cyc]));
    chk("pixel", 32'(bus.fg_pixel_in), 32'(e_rdy[cyc] ? e_pix[cyc] : 16'h0000));
    chk("sram_re", 32'(bus.sram_re), 32'(e_re[cyc]));
    chk("sram_we", 32'(bus.sram_we), 32'(e_we[cyc]));
    chk("re_we_excl", 32'(bus.sram_re && bus.sram_we), 32'(0));
    if (e_re[cyc] || e_we[cyc]) chk("sram_addr", 32'(bus.sram_addr), 32'(e_ad[cyc]));
    if (e_we[cyc]) chk("sram_wdata", 32'(bus.sram_wdata), 32'(e_wd[cyc]));
    chk("read_page", 32'(read_page), 32'(m_page));

    x   = int'(bus.req_x);
    y   = int'(bus.req_y);
    inr = (x >= 0) && (x < RX) && (y >= 0) && (y < RY);
    chk("wr_ready", 32'(bus.wr_ready), 32'(!rst && !(bus.req_active && inr)));

    // environment SRAM acts on whatever the DUT drives
    env_re[cyc] = bus.sram_re;
    if (bus.sram_re) env_rd[cyc] = env_read(int'(bus.sram_addr));
    if (bus.sram_we) mem_env[int'(bus.sram_addr)] = bus.sram_wdata;

    // reference model
    if (!rst) begin
      if (bus.req_active) begin
        e_rdy[cyc+int'(FD)] = 1;
        e_skp[cyc+int'(FD)] = !inr;
        e_pix[cyc+int'(FD)] = '0;
        if (inr) begin
          a = int'(m_page) * (1 << 21) + y * RX + x;
          e_pix[cyc+int'(FD)] = ref_rd(a);
          e_re[cyc+1] = 1;
          e_ad[cyc+1] = AW'(a);
        end
      end
      if (bus.wr_valid && !(bus.req_active && inr)) begin
        a = int'(!m_page) * (1 << 21) + int'(bus.wr_addr);
        e_we[cyc+1] = 1;
        e_ad[cyc+1] = AW'(a);
        e_wd[cyc+1] = bus.wr_data;
        mem_ref[a]  = bus.wr_data;
      end
      if (frame_start && (m_pend || swap_req)) begin
        m_page = !m_page;
        m_pend = 0;
      end else if (swap_req) begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Random request biased toward the first rows so writes get read back.
  task automatic rand_cycle(input bit wr_hold);
    int x, y;
    x = (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 15))
                                    : int'($urandom_range(0, 2100)) - 100);
    y = (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                    : int'($urandom_range(0, 1200)) - 60);
    set_req($urandom_range(0, 3) != 0, x, y);
    bus.wr_valid = wr_hold ? 1'b1 : ($urandom_range(0, 1) == 1);
    bus.wr_addr  = 21'(($urandom_range(0, 3) * RX) + int'($urandom_range(0, 15)));
    bus.wr_data  = 16'($urandom);
    step();
  endtask

  task automatic idle(input int n);
    set_req(0, 0, 0);
    bus.wr_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int bx [6];
    int by [6];
    checks = 0; failures = 0; cyc = 0;
    m_page = 0; m_pend = 0;
    rst = 1; swap_req = 0; frame_start = 0;
    set_req(0, 0, 0);
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.sram_rdata = '0;
    @(posedge clk);
    #1;
    // reset state
    for (int i = 0; i < 3; i++) step();
    rst = 0;

    // single in-range request at cycle 10
    while (cyc < 10) idle(1);
    mem_ref[3845] = 16'hF800;
    mem_env[3845] = 16'hF800;
    set_req(1, 5, 2);
    step();
    idle(6);

    // boundary coordinates back to back
    bx[0] = -1;   by[0] = 0;
    bx[1] = 1920; by[1] = 5;
    bx[2] = 3;    by[2] = 1080;
    bx[3] = 0;    by[3] = 0;
    bx[4] = 1919; by[4] = 1079;
    bx[5] = 7;    by[5] = -1;
    for (int i = 0; i < 6; i++) begin
      set_req(1, bx[i], by[i]);
      step();
    end
    idle(6);

    // continuous traffic with the writer always pending
    for (int i = 0; i < 200; i++) rand_cycle(1);

    // swap, then frame start 100 cycles later
    swap_req = 1; rand_cycle(1); swap_req = 0;
    for (int i = 0; i < 99; i++) rand_cycle(1);
    frame_start = 1; rand_cycle(1); frame_start = 0;
    for (int i = 0; i < 40; i++) rand_cycle(0);
    // frame start without a pending swap
    frame_start = 1; rand_cycle(0); frame_start = 0;
    for (int i = 0; i < 30; i++) rand_cycle(0);
    // swap and frame start in the same cycle
    swap_req = 1; frame_start = 1; rand_cycle(1);
    swap_req = 0; frame_start = 0;
    for (int i = 0; i < 30; i++) rand_cycle(1);
    // repeated swap while pending gives a single toggle
    swap_req = 1; rand_cycle(1); rand_cycle(1); swap_req = 0;
    for (int i = 0; i < 5; i++) rand_cycle(1);
    frame_start = 1; rand_cycle(1); frame_start = 0;
    for (int i = 0; i < 20; i++) rand_cycle(1);

    // random page events
    for (int i = 0; i < 400; i++) begin
      swap_req    = ($urandom_range(0, 49) == 0);
      frame_start = ($urandom_range(0, 49) == 0);
      rand_cycle(0);
    end
    swap_req = 0; frame_start = 0;
    idle(6);

    // reset with responses in flight
    for (int i = 0; i < 6; i++) begin
      set_req(1, int'($urandom_range(0, 1919)), int'($urandom_range(0, 1079)));
      bus.wr_valid = 0;
      step();
    end
    idle(2);
    rst = 1;
    idle(3);
    rst = 0;
    set_req(1, 100, 200);
    step();
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
